// File: rtl/apb_requester.sv
// -----------------------------------------------------------------------------
// apb_requester
//
// Purpose:
//   Turns a simple valid/ready command stream into single APB transfers.
//   Each accepted command becomes one SETUP cycle followed by one or more
//   ACCESS cycles. The completion is reported by a one-cycle rsp_valid pulse.
//   The response fields then hold until the next completion.
//
// Configuration:
//   APB_REQ_TIMEOUT_EN - when defined, a 16-bit wait counter aborts any
//                        transfer that sees TIMEOUT_CYCLES ACCESS cycles
//                        without PREADY. The abort reports rsp_err=1 and
//                        rsp_timeout=1. When undefined, ACCESS waits forever
//                        and rsp_timeout is tied to 0.
//
// Parameters:
//   TIMEOUT_CYCLES  maximum ACCESS cycles without PREADY (1..65535); used only
//                   with APB_REQ_TIMEOUT_EN
//
// Ports:
//   PCLK, PRESETn                   clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_write, cmd_addr, cmd_wdata  command payload
//   rsp_valid                       one-cycle completion pulse
//   rsp_rdata, rsp_err, rsp_timeout completion status, held until next one
//   PSELx, PENABLE, PWRITE, PADDR,
//   PWDATA                          APB requester outputs (all registered)
//   PRDATA, PREADY, PSLVERR         APB completer inputs, sampled in ACCESS
// -----------------------------------------------------------------------------
module apb_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        PSELx,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state;

`ifdef APB_REQ_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;
`endif

  // Ready is gated by PRESETn so that no accept is advertised while reset
  // is held. Ready returns as soon as reset releases.
  assign cmd_ready = PRESETn && (state == IDLE);

`ifndef APB_REQ_TIMEOUT_EN
  assign rsp_timeout = 1'b0;
`endif

  // Single FSM process. Every APB and response output is a register here.
  // The address, data and direction registers change only on an accept. They
  // therefore stay stable for the whole transfer and keep their value afterwards.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_REQ_TIMEOUT_EN
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            PWRITE  <= cmd_write;
            PADDR   <= cmd_addr;
            PWDATA  <= cmd_wdata;
            PSELx   <= 1'b1;
            PENABLE <= 1'b0;
            state   <= SETUP;
          end
        end

        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
`ifdef APB_REQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end

        ACCESS: begin
          // PREADY is checked first. A completer that answers in the final
          // allowed cycle still finishes normally and does not time out.
          if (PREADY) begin
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= PSLVERR;
            rsp_rdata <= PWRITE ? 32'd0 : PRDATA;
`ifdef APB_REQ_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            state     <= IDLE;
          end
`ifdef APB_REQ_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end

        default: begin
          PSELx   <= 1'b0;
          PENABLE <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// -----------------------------------------------------------------------------
// tb_apb_requester
//
// Purpose:
//   Self-checking bench for apb_requester. A transaction-level model predicts
//   the outputs from the transfer timing rules:
//     - SETUP occurs in the cycle after an accept.
//     - ACCESS lasts until PREADY is seen, or until the timeout when
//       APB_REQ_TIMEOUT_EN is defined.
//     - The completion pulse appears in the following cycle.
//   The model is compared against the DUT on every cycle. Directed
//   transfers add hand-computed literal checks.
//
// Configuration:
//   APB_REQ_TIMEOUT_EN - follows the DUT build and selects which timeout
//                        behaviour is expected.
// -----------------------------------------------------------------------------
module tb_apb_requester;

  localparam int TMO   = 16;
  localparam int NCYC  = 8192;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  apb_requester #(.TIMEOUT_CYCLES(TMO)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSELx       (PSELx),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;

  // Settings for the completer model. PREADY rises after wait_target wait
  // cycles unless hold_low is set.
  int          wait_target = 0;
  bit          hold_low    = 1'b0;
  logic        slverr_val  = 1'b0;
  logic [31:0] rdata_val   = '0;
  int          acc_cnt     = 0;

  // Expected-output timeline for the model, indexed by cycle number.
  bit          psel_exp [0:NCYC-1];
  bit          pen_exp  [0:NCYC-1];
  bit          rv_exp   [0:NCYC-1];
  int          k = 0;
  int          waits = 0;
  logic        exp_write = 1'b0;
  logic [31:0] exp_addr  = '0;
  logic [31:0] exp_wdata = '0;
  logic [31:0] exp_rdata = '0;
  logic        exp_err   = 1'b0;
  logic        exp_tmo   = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(posedge PCLK) edge_cnt++;

  // Completer model. It reacts just after each edge to the state of the
  // requester. Outside ACCESS it drives deliberately misleading values so
  // that any sampling of PREADY, PSLVERR or PRDATA at the wrong time shows up.
  always @(posedge PCLK) begin
    #1;
    if (PSELx && PENABLE) begin
      acc_cnt++;
      PREADY  = !hold_low && (acc_cnt > wait_target);
      PSLVERR = slverr_val;
      PRDATA  = rdata_val;
    end else begin
      acc_cnt = 0;
      PREADY  = 1'b1;
      PSLVERR = 1'b1;
      PRDATA  = 32'hDEAD_BEEF;
    end
  end

  // Model and compare process. At each falling edge it checks the current
  // cycle against the timeline. It then extends the timeline using the inputs
  // that the next rising edge will sample.
  always @(negedge PCLK) begin
    if (!PRESETn) begin
      for (int i = 0; i < 4; i++) begin
        psel_exp[k+i] = 1'b0;
        pen_exp[k+i]  = 1'b0;
        rv_exp[k+i]   = 1'b0;
      end
      exp_write = 1'b0;
      exp_addr  = '0;
      exp_wdata = '0;
      exp_rdata = '0;
      exp_err   = 1'b0;
      exp_tmo   = 1'b0;
      waits     = 0;
    end
    checkOutput("cmd_ready",   cmd_ready,   PRESETn && !psel_exp[k]);
    checkOutput("PSELx",       PSELx,       psel_exp[k]);
    checkOutput("PENABLE",     PENABLE,     pen_exp[k]);
    checkOutput("rsp_valid",   rsp_valid,   rv_exp[k]);
    checkOutput("PWRITE",      PWRITE,      exp_write);
    checkOutput("PADDR",       PADDR,       exp_addr);
    checkOutput("PWDATA",      PWDATA,      exp_wdata);
    checkOutput("rsp_rdata",   rsp_rdata,   exp_rdata);
    checkOutput("rsp_err",     rsp_err,     exp_err);
    checkOutput("rsp_timeout", rsp_timeout, exp_tmo);
    if (PRESETn) begin
      if (!psel_exp[k] && cmd_valid) begin
        exp_write     = cmd_write;
        exp_addr      = cmd_addr;
        exp_wdata     = cmd_wdata;
        psel_exp[k+1] = 1'b1;
        psel_exp[k+2] = 1'b1;
        pen_exp[k+2]  = 1'b1;
        waits         = 0;
      end else if (pen_exp[k]) begin
        if (PREADY) begin
          rv_exp[k+1] = 1'b1;
          exp_err     = PSLVERR;
          exp_rdata   = exp_write ? 32'd0 : PRDATA;
          exp_tmo     = 1'b0;
        end else begin
          waits++;
`ifdef APB_REQ_TIMEOUT_EN
          if (waits == TMO) begin
            rv_exp[k+1] = 1'b1;
            exp_err     = 1'b1;
            exp_tmo     = 1'b1;
            exp_rdata   = '0;
          end else begin
            psel_exp[k+1] = 1'b1;
            pen_exp[k+1]  = 1'b1;
          end
`else
          psel_exp[k+1] = 1'b1;
          pen_exp[k+1]  = 1'b1;
`endif
        end
      end
    end
    if (k < NCYC - 8) k++;
  end

  // Presents a command and waits for it to be accepted. t0 is the number of
  // the accept edge.
  task automatic issueCmd(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output int t0);
    bit got = 1'b0;
    @(posedge PCLK); #1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge PCLK);
      if (cmd_ready) got = 1'b1;
    end
    @(posedge PCLK); #1;
    t0 = edge_cnt;
    cmd_valid = 1'b0;
    if (!got) checkOutput("cmd_accept", 32'd0, 32'd1);
  endtask

  // Waits for the completion pulse. lat = n means the pulse arrived in cycle
  // T0+n.
  task automatic waitRsp(input int t0, input int budget, output int lat);
    bit got = 1'b0;
    lat = -1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge PCLK);
      if (rsp_valid) got = 1'b1;
    end
    if (got) lat = edge_cnt - t0 + 1;
    else checkOutput("rsp_valid_wait", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input int w,
                               input logic err, input logic [31:0] rd,
                               output int lat);
    int t0;
    wait_target = w;
    hold_low    = 1'b0;
    slverr_val  = err;
    rdata_val   = rd;
    issueCmd(wr, addr, wdata, t0);
    waitRsp(t0, 100, lat);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int t0;
    int n;
    bit got;
    bit acc;
    int accept_edge [0:3];
    logic        tbl_wr    [0:3];
    logic [31:0] tbl_addr  [0:3];
    logic [31:0] tbl_wdata [0:3];

    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    PREADY    = 1'b1;
    PSLVERR   = 1'b0;
    PRDATA    = '0;

    @(posedge PCLK); @(posedge PCLK); #1;
    checkOutput("reset_cmd_ready", cmd_ready, 32'd0);
    checkOutput("reset_psel", PSELx, 32'd0);
    #1 PRESETn = 1'b1;
    #1 checkOutput("release_cmd_ready", cmd_ready, 32'd1);

    $display("[TB] zero-wait write");
    applyStimulus(1'b1, 32'h8, 32'h0000_1234, 0, 1'b0, 32'h5555_5555, lat);
    checkOutput("wr_latency", lat, 32'd3);
    checkOutput("wr_rdata", rsp_rdata, 32'd0);
    checkOutput("wr_err", rsp_err, 32'd0);

    $display("[TB] read with three wait states");
    applyStimulus(1'b0, 32'h4, 32'h0, 3, 1'b0, 32'hA5A5_A5A5, lat);
    checkOutput("rd_latency", lat, 32'd6);
    checkOutput("rd_rdata", rsp_rdata, 32'hA5A5_A5A5);
    checkOutput("rd_err", rsp_err, 32'd0);

    $display("[TB] write with slave error");
    applyStimulus(1'b1, 32'h2, 32'h0000_00EE, 0, 1'b1, 32'h0, lat);
    checkOutput("err_latency", lat, 32'd3);
    checkOutput("err_err", rsp_err, 32'd1);
    checkOutput("err_timeout", rsp_timeout, 32'd0);

    $display("[TB] read with one wait state");
    applyStimulus(1'b0, 32'h40, 32'h0, 1, 1'b0, 32'h1357_9BDF, lat);
    checkOutput("rd1_latency", lat, 32'd4);
    checkOutput("rd1_rdata", rsp_rdata, 32'h1357_9BDF);

    $display("[TB] completer never ready");
    wait_target = 0;
    hold_low    = 1'b1;
    slverr_val  = 1'b0;
    rdata_val   = 32'h0BAD_F00D;
    issueCmd(1'b0, 32'h10, 32'h0, t0);
`ifdef APB_REQ_TIMEOUT_EN
    waitRsp(t0, 60, lat);
    checkOutput("tmo_latency", lat, 32'd18);
    checkOutput("tmo_err", rsp_err, 32'd1);
    checkOutput("tmo_timeout", rsp_timeout, 32'd1);
    checkOutput("tmo_rdata", rsp_rdata, 32'd0);
    hold_low = 1'b0;
`else
    repeat (100) @(negedge PCLK);
    checkOutput("stuck_psel", PSELx, 32'd1);
    checkOutput("stuck_penable", PENABLE, 32'd1);
    hold_low = 1'b0;
    waitRsp(t0, 10, lat);
    checkOutput("late_rdata", rsp_rdata, 32'h0BAD_F00D);
    checkOutput("late_err", rsp_err, 32'd0);
`endif

    $display("[TB] reset in the second wait cycle");
    wait_target = 0;
    hold_low    = 1'b1;
    rdata_val   = 32'h1111_2222;
    issueCmd(1'b0, 32'h20, 32'h0, t0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge PCLK);
      if (PSELx && PENABLE && acc_cnt == 2) got = 1'b1;
    end
    checkOutput("reach_wait2", got, 32'd1);
    #2;
    PRESETn   = 1'b0;
    cmd_write = 1'b1;
    cmd_addr  = 32'h30;
    cmd_wdata = 32'hCAFE_0030;
    cmd_valid = 1'b1;
    hold_low  = 1'b0;
    #1;
    checkOutput("rst_psel", PSELx, 32'd0);
    checkOutput("rst_penable", PENABLE, 32'd0);
    checkOutput("rst_rsp_valid", rsp_valid, 32'd0);
    @(posedge PCLK); @(posedge PCLK); #2;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    t0 = edge_cnt;
    cmd_valid = 1'b0;
    checkOutput("post_rst_psel", PSELx, 32'd1);
    checkOutput("post_rst_penable", PENABLE, 32'd0);
    checkOutput("post_rst_paddr", PADDR, 32'h30);
    waitRsp(t0, 20, lat);
    checkOutput("post_rst_latency", lat, 32'd3);
    checkOutput("post_rst_err", rsp_err, 32'd0);

    $display("[TB] four back-to-back commands");
    tbl_wr[0] = 1'b1; tbl_addr[0] = 32'h100; tbl_wdata[0] = 32'h0000_0001;
    tbl_wr[1] = 1'b0; tbl_addr[1] = 32'h104; tbl_wdata[1] = 32'h0;
    tbl_wr[2] = 1'b1; tbl_addr[2] = 32'h108; tbl_wdata[2] = 32'h0000_0003;
    tbl_wr[3] = 1'b0; tbl_addr[3] = 32'h10C; tbl_wdata[3] = 32'h0;
    wait_target = 0;
    hold_low    = 1'b0;
    slverr_val  = 1'b0;
    rdata_val   = 32'h7777_8888;
    @(posedge PCLK); #1;
    cmd_write = tbl_wr[0];
    cmd_addr  = tbl_addr[0];
    cmd_wdata = tbl_wdata[0];
    cmd_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge PCLK);
      acc = cmd_ready && cmd_valid;
      @(posedge PCLK); #1;
      if (acc) begin
        accept_edge[n] = edge_cnt;
        n++;
        if (n < 4) begin
          cmd_write = tbl_wr[n];
          cmd_addr  = tbl_addr[n];
          cmd_wdata = tbl_wdata[n];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    checkOutput("b2b_count", n, 32'd4);
    if (n == 4) begin
      for (int i = 1; i < 4; i++)
        checkOutput("b2b_spacing", accept_edge[i] - accept_edge[i-1], 32'd3);
      waitRsp(accept_edge[3], 20, lat);
      checkOutput("b2b_latency", lat, 32'd3);
      checkOutput("b2b_rdata", rsp_rdata, 32'h7777_8888);
    end

    repeat (3) @(negedge PCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_requester.md
APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of ACCESS cycles without PREADY (legal range 1..65535; used only when APB_REQ_TIMEOUT_EN is defined).
REQ-002 SHALL have port PCLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port PRESETn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port cmd_valid  input  1  a transfer request is presented.
REQ-005 SHALL have port cmd_ready  output  1  the request is accepted on this edge when cmd_valid is also 1.
REQ-006 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr  input  32  target address.
REQ-008 SHALL have port cmd_wdata  input  32  write data.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata  output  32  read data, 0 for writes and timeouts.
REQ-011 SHALL have port rsp_err  output  1  PSLVERR was sampled, or the transfer timed out.
REQ-012 SHALL have port rsp_timeout  output  1  the completion was caused by timeout.
REQ-013 SHALL have the APB ports PSELx, PENABLE and PWRITE (each output, 1), PADDR and PWDATA (each output, 32), PRDATA (input, 32), and PREADY and PSLVERR (each input, 1).

Function
REQ-014 SHALL implement the FSM states IDLE, SETUP and ACCESS, with cmd_ready=1 only in IDLE.
REQ-015 SHALL, when cmd_valid&cmd_ready is sampled at edge T0, register cmd_write/cmd_addr/cmd_wdata onto PWRITE/PADDR/PWDATA and enter SETUP (PSELx=1, PENABLE=0).
REQ-016 SHALL go from SETUP to ACCESS unconditionally after one cycle (PSELx=1, PENABLE=1).
REQ-017 SHALL hold PADDR/PWRITE/PWDATA stable from SETUP through the last ACCESS cycle and change them only on a new accept.
REQ-018 SHALL stay in ACCESS while PREADY=0 (wait states), with no limit unless the timeout is compiled in.
REQ-019 SHALL, on the edge where PREADY=1 is sampled in ACCESS, go to IDLE, drive PSELx=0 and PENABLE=0, and pulse rsp_valid=1 for exactly the next cycle.
REQ-020 SHALL, in that completion cycle, set rsp_err=PSLVERR (sampled), set rsp_rdata=PRDATA for a read and 0 for a write, and set rsp_timeout=0.
REQ-021 SHALL complete a zero-wait transfer with rsp_valid in cycle T0+3, and SHALL allow the next accept at the edge that ends that rsp_valid cycle (minimum 3 cycles per transfer).
REQ-022 SHALL hold rsp_rdata/rsp_err/rsp_timeout until the next completion, and SHALL NOT apply backpressure on rsp_valid.
REQ-023 SHALL ignore cmd_valid outside IDLE; the requester holds its command until cmd_ready.
REQ-024 SHALL ignore PREADY, PSLVERR and PRDATA outside ACCESS.

Reset
REQ-025 SHALL, while PRESETn=0, force state=IDLE, PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0 and wait counter=0, with cmd_ready=0 while reset is asserted.
REQ-026 SHALL, when reset asserts mid-transfer, drop the transfer with no rsp_valid, and SHALL allow a first accept at the first edge after release.

Configuration
REQ-027 SHALL, with APB_REQ_TIMEOUT_EN defined, use a 16-bit wait counter that clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
REQ-028 SHALL, with APB_REQ_TIMEOUT_EN defined, when the counter equals TIMEOUT_CYCLES-1 and PREADY=0, abort to IDLE and pulse rsp_valid with rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
REQ-029 SHALL, with APB_REQ_TIMEOUT_EN defined, give PREADY=1 in that same final cycle priority, so the transfer completes normally.
REQ-030 SHALL, without APB_REQ_TIMEOUT_EN, contain no counter, tie rsp_timeout to 0, and wait in ACCESS indefinitely.

Verification
REQ-031 SHALL cover: write addr 0x8, data 0x00001234, PREADY=1 always -> PSELx high for T1..T2, PENABLE high for T2, rsp_valid at T3, rsp_err=0, rsp_rdata=0.
REQ-032 SHALL cover: read addr 0x4, PREADY low for 3 ACCESS cycles, PRDATA=0xA5A5A5A5 -> rsp_valid at T0+6, rsp_rdata=0xA5A5A5A5, PADDR stable throughout.
REQ-033 SHALL cover: write addr 0x2 with PSLVERR=1 at PREADY -> rsp_err=1, rsp_timeout=0.
REQ-034 SHALL cover: macro defined, TIMEOUT_CYCLES=16, PREADY held 0 -> rsp_valid after 16 ACCESS cycles with rsp_err=1, rsp_timeout=1; macro undefined -> still in ACCESS after 100 cycles.
REQ-035 SHALL cover: PRESETn=0 asserted in the 2nd ACCESS wait cycle -> PSELx/PENABLE go 0 immediately, no rsp_valid, and a new command is accepted at the first edge after release.
REQ-036 SHALL cover: cmd_valid held high continuously for 4 commands -> accepts every 3 cycles, and no PSELx gap shorter than 1 cycle between transfers.
